// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision add/subtract
// one-bit-per-cycle align and normalise, round-to-nearest-even
module fp_addsub_seq #(
  parameter int MAX_LAT = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] ALIGN  = 3'd2;
  localparam logic [2:0] ADD    = 3'd3;
  localparam logic [2:0] NORM   = 3'd4;
  localparam logic [2:0] ROUND  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  // worst path is a 26-step align plus one normalise step: 33 cycles
  if (MAX_LAT < 33) begin : g_lat_chk
    $error("MAX_LAT below worst-case latency of 33");
  end

  logic [2:0]  state;
  logic [31:0] ra, rb;
  logic        rsub;
  logic        sa, sb;
  logic [8:0]  e, diff;
  logic [27:0] ma, mb, m;

  logic [8:0]  xa_e, xb_e;
  logic [27:0] xa_m, xb_m;
  logic        xb_s, swap;
  logic        eff_sub;
  logic [27:0] sum;
  logic [7:0]  enc;
  logic        up;
  logic [30:0] rnd;

  // mantissa layout: [27] carry, [26] hidden, [25:3] frac, [2:0] g/r/s
  always_comb begin
    xa_e    = (ra[30:23] == 8'd0) ? 9'd1 : {1'b0, ra[30:23]};
    xb_e    = (rb[30:23] == 8'd0) ? 9'd1 : {1'b0, rb[30:23]};
    xa_m    = {1'b0, |ra[30:23], ra[22:0], 3'b000};
    xb_m    = {1'b0, |rb[30:23], rb[22:0], 3'b000};
    xb_s    = rb[31] ^ rsub;
    swap    = rb[30:0] > ra[30:0];
    eff_sub = sa ^ sb;
    sum     = eff_sub ? ma - mb : ma + mb;
    enc     = m[26] ? e[7:0] : 8'd0;
    up      = m[2] & (m[3] | m[1] | m[0]);
    rnd     = {enc, m[25:3]} + {30'd0, up};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rsub  <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      e     <= '0;
      diff  <= '0;
      ma    <= '0;
      mb    <= '0;
      m     <= '0;
      s     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            rsub  <= sub;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          if (swap) begin
            sa   <= xb_s;
            sb   <= ra[31];
            e    <= xb_e;
            ma   <= xb_m;
            mb   <= xa_m;
            diff <= xb_e - xa_e;
          end else begin
            sa   <= ra[31];
            sb   <= xb_s;
            e    <= xa_e;
            ma   <= xa_m;
            mb   <= xb_m;
            diff <= xa_e - xb_e;
          end
          state <= ALIGN;
        end
        ALIGN: begin
          if (diff == 9'd0) begin
            state <= ADD;
          end else if (diff > 9'd26) begin
            mb   <= {27'd0, |mb};
            diff <= 9'd0;
          end else begin
            mb   <= {1'b0, mb[27:2], |mb[1:0]};
            diff <= diff - 9'd1;
          end
        end
        ADD: begin
          if (sum[27]) begin
            m <= {1'b0, sum[27:2], |sum[1:0]};
            e <= e + 9'd1;
          end else begin
            m <= sum;
          end
          if (eff_sub && sum == 28'd0) sa <= 1'b0;
          state <= NORM;
        end
        NORM: begin
          if (!m[26] && e > 9'd1 && m != 28'd0) begin
            m <= {m[26:0], 1'b0};
            e <= e - 9'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          s     <= {sa, rnd};
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: vector table, corner sequences and random ops
// checked through a scoreboard against an exact integer model
module tb_fp_addsub_seq;

  localparam int MAX_LAT = 60;

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [31:0] a, b, s;
  logic        busy, done;

  always #5 clk = ~clk;

  fp_addsub_seq #(.MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b), .s(s), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] s;
    bit          care;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // exact wide-integer sum in units of 2^-149, then RNE; bit 32 = overflow
  function automatic logic [32:0] fp_ref(input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic sb);
    logic [279:0] mx, my, mag, keep, rem, half;
    logic [31:0]  fld;
    logic         sx, sy, sr;
    int           ex, ey, p, sh;
    ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
    mx = 280'({|x[30:23], x[22:0]}) << (ex - 1);
    my = 280'({|y[30:23], y[22:0]}) << (ey - 1);
    sx = x[31];
    sy = y[31] ^ sb;
    if (sx == sy) begin
      mag = mx + my;
      sr  = sx;
    end else if (mx >= my) begin
      mag = mx - my;
      sr  = (mag == '0) ? 1'b0 : sx;
    end else begin
      mag = my - mx;
      sr  = sy;
    end
    if (mag == '0) return {1'b0, sr, 31'd0};
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    if (p <= 23) return {1'b0, sr, mag[30:0]};
    sh   = p - 23;
    keep = mag >> sh;
    rem  = mag & ((280'd1 << sh) - 280'd1);
    half = 280'd1 << (sh - 1);
    fld  = (32'(sh + 1) << 23) | {9'd0, keep[22:0]};
    if (rem > half || (rem == half && keep[0])) fld = fld + 32'd1;
    return {fld[31:23] >= 9'd255, sr, fld[30:0]};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk(1'b0, "spurious_done", s, 32'h0);
      end else begin
        exp_t ex;
        ex = sb_q.pop_front();
        if (ex.care) chk(s === ex.s, "result", s, ex.s);
      end
    end
  end

  task automatic wait_done(input int lat0);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat <= MAX_LAT + 4) begin
      @(negedge clk);
      lat++;
    end
    chk(lat <= MAX_LAT, "latency", 32'(lat), 32'(MAX_LAT));
    chk(busy === 1'b0, "busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk(done === 1'b0, "done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic issue(input logic [31:0] xa, input logic [31:0] xb,
                       input logic xs, input logic [31:0] xe,
                       input bit care);
    a     = xa;
    b     = xb;
    sub   = xs;
    start = 1'b1;
    sb_q.push_back('{s: xe, care: care});
    @(negedge clk);
    start = 1'b0;
    chk(busy === 1'b1, "busy_rise", {31'd0, busy}, 32'd1);
    wait_done(1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    vt[0]  = '{32'h3F800001, 32'hBF800001, 1'b0, 32'h00000000};
    vt[1]  = '{32'h40000000, 32'h34000000, 1'b0, 32'h40000000};
    vt[2]  = '{32'h40000000, 32'h34000001, 1'b0, 32'h40000001};
    vt[3]  = '{32'h407fffff, 32'h34400000, 1'b0, 32'h40800000};
    vt[4]  = '{32'h00012832, 32'h0014283c, 1'b1, 32'h8013000a};
    vt[5]  = '{32'h02682174, 32'h026f0850, 1'b1, 32'h803736e0};
    vt[6]  = '{32'h4d064db7, 32'h440d491c, 1'b0, 32'h4d064dda};
    vt[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    vt[8]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000};
    vt[9]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
    vt[10] = '{32'h3f800000, 32'h3f800000, 1'b1, 32'h00000000};
    vt[11] = '{32'h007fffff, 32'h00000001, 1'b0, 32'h00800000};
    vt[12] = '{32'h00800000, 32'h00000001, 1'b1, 32'h007fffff};
    vt[13] = '{32'h3f800000, 32'h33800000, 1'b0, 32'h3f800000};
    vt[14] = '{32'h3f800001, 32'h33800000, 1'b0, 32'h3f800002};
    vt[15] = '{32'h3f800000, 32'h00000001, 1'b0, 32'h3f800000};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    @(negedge clk);
    chk(s === 32'h0, "reset_s", s, 32'h0);
    chk(busy === 1'b0, "reset_busy", {31'd0, busy}, 32'd0);
    chk(done === 1'b0, "reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      issue(vt[i].a, vt[i].b, vt[i].sub, vt[i].s, 1'b1);

    // reset in the middle of a long alignment: no done may follow
    a     = 32'h4d064db7;
    b     = 32'h440d491c;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk(busy === 1'b1, "busy_mid_align", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk(s === 32'h0, "rst_mid_s", s, 32'h0);
    chk(busy === 1'b0, "rst_mid_busy", {31'd0, busy}, 32'd0);
    chk(done === 1'b0, "rst_mid_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'h4d064db7, 32'h440d491c, 1'b0, 32'h4d064dda, 1'b1);

    // second start while busy must be ignored
    a     = 32'h12e1798b;
    b     = 32'h121f73da;
    sub   = 1'b0;
    start = 1'b1;
    sb_q.push_back('{s: 32'h131899bc, care: 1'b1});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a     = 32'h3f800000;
    b     = 32'h40000000;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      logic [7:0]  ea, eb;
      logic [31:0] xa, xb;
      logic        xs;
      logic [32:0] r;
      int          t;
      ea = 8'($urandom_range(0, 254));
      if ($urandom_range(0, 1) == 1) begin
        t = int'(ea) + int'($urandom_range(0, 4)) - 2;
        if (t < 0) t = 0;
        if (t > 254) t = 254;
        eb = 8'(t);
      end else begin
        eb = 8'($urandom_range(0, 254));
      end
      xa = {1'($urandom), ea, 23'($urandom)};
      xb = {1'($urandom), eb, 23'($urandom)};
      xs = 1'($urandom);
      r  = fp_ref(xa, xb, xs);
      issue(xa, xb, xs, r[31:0], !r[32]);
    end

    repeat (5) @(negedge clk);
    chk(sb_q.size() == 0, "pending_results", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
